// File: rtl/bus_codec_pkg.sv
// Shared definitions for the low-power bus codec: mode encodings and a population count.
package bus_codec_pkg;

    localparam logic [1:0] MODE_RAW  = 2'd0;
    localparam logic [1:0] MODE_GRAY = 2'd1;
    localparam logic [1:0] MODE_T0   = 2'd2;
    localparam logic [1:0] MODE_BI   = 2'd3;

    localparam int POP_MAX_W = 64;

    // Callers zero-extend narrower vectors, so bus widths up to 63 bits (plus bus_x) fit.
    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/bus_codec_dec.sv
// Decoder stage: rebuilds the original word from {bus_x, bus} using the mode that travelled with it.
module bus_codec_dec
    import bus_codec_pkg::*;
#(
    parameter int W      = 8,
    parameter int STRIDE = 1
) (
    input  logic         ck,
    input  logic         rst,
    input  logic [W-1:0] bus,
    input  logic         bus_x,
    input  logic [1:0]   mode_q,
    input  logic         bus_valid,
    output logic [W-1:0] dout,
    output logic         dout_valid
);

    localparam logic [W-1:0] STEP = W'(STRIDE);

    logic [W-1:0] dout_reg;
    logic [W-1:0] dout_next;
    logic [W-1:0] gray_dec;
    logic         dout_valid_reg;

    // Gray decode: each output bit is the XOR of all bus bits at or above it.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_gray
            assign gray_dec[gi] = ^bus[W-1:gi];
        end
    endgenerate

    // dout_reg holds between words, so it doubles as the T0 predecessor.
    always_comb begin
        dout_next = bus;
        case (mode_q)
            MODE_GRAY: dout_next = gray_dec;
            MODE_T0:   dout_next = bus_x ? dout_reg + STEP : bus;
            MODE_BI:   dout_next = bus_x ? ~bus : bus;
            default:   dout_next = bus;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
        end else begin
            dout_valid_reg <= bus_valid;
            if (bus_valid) begin
                dout_reg <= dout_next;
            end
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;

endmodule

// File: rtl/bus_lowpower_codec.sv
// Low-power bus codec: registered encoder (raw/Gray/T0/bus-invert), paired decoder,
// and a saturating counter of line flips on {bus_x, bus}.
module bus_lowpower_codec
    import bus_codec_pkg::*;
#(
    parameter int W      = 8,
    parameter int STRIDE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    input  logic [W-1:0]     din,
    input  logic             clr_cnt,
    output logic [W-1:0]     bus,
    output logic             bus_x,
    output logic             bus_valid,
    output logic [W-1:0]     dout,
    output logic             dout_valid,
    output logic [CNT_W-1:0] toggles
);

    localparam logic [W-1:0]     STEP    = W'(STRIDE);
    localparam logic [7:0]       HALF    = 8'(W / 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int               SUM_W   = CNT_W + 8;

    logic [W-1:0]     bus_reg;
    logic [W-1:0]     bus_next;
    logic             bus_x_reg;
    logic             bus_x_next;
    logic             bus_valid_reg;
    logic [1:0]       mode_q_reg;
    logic [W-1:0]     prev_din_reg;
    logic [1:0]       last_mode_reg;
    logic             hist_valid_reg;
    logic [CNT_W-1:0] toggles_reg;
    logic [CNT_W-1:0] toggles_next;
    logic [SUM_W-1:0] tog_sum;
    logic [7:0]       hamming;
    logic [7:0]       flips;
    logic             mode_change;
    logic             t0_hit;
    logic             bi_invert;

    always_comb begin
        // A mode switch forces the word out plain and discards T0 history.
        mode_change = hist_valid_reg && (mode != last_mode_reg);
        hamming     = 8'(popcount(64'(din ^ bus_reg)));
        t0_hit      = hist_valid_reg && !mode_change && (din == prev_din_reg + STEP);
        bi_invert   = !mode_change && (hamming > HALF);

        bus_next   = bus_reg;
        bus_x_next = bus_x_reg;
        if (in_valid) begin
            bus_x_next = 1'b0;
            case (mode)
                MODE_GRAY: bus_next = din ^ (din >> 1);
                MODE_T0: begin
                    if (t0_hit) begin
                        bus_next   = bus_reg;
                        bus_x_next = 1'b1;
                    end else begin
                        bus_next = din;
                    end
                end
                MODE_BI: begin
                    if (bi_invert) begin
                        bus_next   = ~din;
                        bus_x_next = 1'b1;
                    end else begin
                        bus_next = din;
                    end
                end
                default: bus_next = din;
            endcase
        end

        flips   = 8'(popcount(64'({bus_x_next, bus_next} ^ {bus_x_reg, bus_reg})));
        tog_sum = SUM_W'(toggles_reg) + SUM_W'(flips);
        if (clr_cnt) begin
            toggles_next = '0;
        end else if (tog_sum > SUM_W'(CNT_MAX)) begin
            toggles_next = CNT_MAX;
        end else begin
            toggles_next = CNT_W'(tog_sum);
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            bus_reg        <= '0;
            bus_x_reg      <= 1'b0;
            bus_valid_reg  <= 1'b0;
            mode_q_reg     <= MODE_RAW;
            prev_din_reg   <= '0;
            last_mode_reg  <= MODE_RAW;
            hist_valid_reg <= 1'b0;
            toggles_reg    <= '0;
        end else begin
            bus_reg       <= bus_next;
            bus_x_reg     <= bus_x_next;
            bus_valid_reg <= in_valid;
            toggles_reg   <= toggles_next;
            if (in_valid) begin
                mode_q_reg     <= mode;
                prev_din_reg   <= din;
                last_mode_reg  <= mode;
                hist_valid_reg <= 1'b1;
            end
        end
    end

    bus_codec_dec #(
        .W      (W),
        .STRIDE (STRIDE)
    ) u_dec (
        .ck         (ck),
        .rst        (rst),
        .bus        (bus_reg),
        .bus_x      (bus_x_reg),
        .mode_q     (mode_q_reg),
        .bus_valid  (bus_valid_reg),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    assign bus       = bus_reg;
    assign bus_x     = bus_x_reg;
    assign bus_valid = bus_valid_reg;
    assign toggles   = toggles_reg;

endmodule

// File: tb/tb_bus_lowpower_codec.sv
// Scoreboard bench: directed cases then random traffic against a behavioural codec model,
// run on a 16-bit-counter instance and a 4-bit-counter instance sharing the same stimulus.
module tb_bus_lowpower_codec;

    localparam int W      = 8;
    localparam int STRIDE = 1;

    logic         ck = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   mode = 2'd0;
    logic         in_valid = 1'b0;
    logic [W-1:0] din = '0;
    logic         clr_cnt = 1'b0;

    logic [W-1:0] bus, bus_c, dout, dout_c;
    logic         bus_x, bus_x_c, bus_valid, bus_valid_c, dout_valid, dout_valid_c;
    logic [15:0]  toggles;
    logic [3:0]   toggles_c;

    bus_lowpower_codec #(.W(W), .STRIDE(STRIDE), .CNT_W(16)) dut (
        .ck(ck), .rst(rst), .mode(mode), .in_valid(in_valid), .din(din), .clr_cnt(clr_cnt),
        .bus(bus), .bus_x(bus_x), .bus_valid(bus_valid), .dout(dout), .dout_valid(dout_valid),
        .toggles(toggles)
    );

    bus_lowpower_codec #(.W(W), .STRIDE(STRIDE), .CNT_W(4)) dut_c (
        .ck(ck), .rst(rst), .mode(mode), .in_valid(in_valid), .din(din), .clr_cnt(clr_cnt),
        .bus(bus_c), .bus_x(bus_x_c), .bus_valid(bus_valid_c), .dout(dout_c), .dout_valid(dout_valid_c),
        .toggles(toggles_c)
    );

    always #5 ck = ~ck;

    typedef struct packed {
        logic         v;
        logic [W-1:0] b;
        logic         x;
        logic [15:0]  tog;
        logic [3:0]   togc;
    } cyc_t;

    cyc_t         cyc_q[$];
    logic [W-1:0] dec_q[$];
    logic [W-1:0] dec_c_q[$];

    logic [W-1:0] m_bus, m_prev;
    logic         m_x, m_hist;
    logic [1:0]   m_mode;
    int           m_tog, m_togc;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_bus = '0; m_prev = '0; m_x = 1'b0; m_hist = 1'b0; m_mode = 2'd0;
        m_tog = 0; m_togc = 0;
        cyc_q.delete(); dec_q.delete(); dec_c_q.delete();
    endtask

    // One clock of stimulus; the expected result of the coming edge is queued.
    task automatic drive(input logic v, input logic [1:0] md, input logic [W-1:0] d, input logic c);
        logic [W-1:0] nb;
        logic         nx, changed;
        int           f;
        cyc_t         e;
        @(negedge ck);
        in_valid = v; mode = md; din = d; clr_cnt = c;
        nb = m_bus; nx = m_x;
        if (v) begin
            changed = m_hist && (md != m_mode);
            nx = 1'b0;
            nb = d;
            if (md == 2'd1) begin
                nb = d ^ (d >> 1);
            end else if (md == 2'd2) begin
                if (m_hist && !changed && d == W'(m_prev + W'(STRIDE))) begin
                    nb = m_bus; nx = 1'b1;
                end
            end else if (md == 2'd3) begin
                if (!changed && $countones(d ^ m_bus) > W / 2) begin
                    nb = ~d; nx = 1'b1;
                end
            end
            dec_q.push_back(d);
            dec_c_q.push_back(d);
            m_prev = d; m_mode = md; m_hist = 1'b1;
            $display("txn mode=%0d din=%02h -> bus=%02h bus_x=%0b", md, d, nb, nx);
        end
        f = $countones({nx, nb} ^ {m_x, m_bus});
        m_tog  = c ? 0 : ((m_tog + f > 65535) ? 65535 : m_tog + f);
        m_togc = c ? 0 : ((m_togc + f > 15) ? 15 : m_togc + f);
        m_bus = nb; m_x = nx;
        e.v = v; e.b = nb; e.x = nx; e.tog = 16'(m_tog); e.togc = 4'(m_togc);
        cyc_q.push_back(e);
    endtask

    task automatic do_reset(input bit check_zero);
        @(negedge ck);
        rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0;
        model_clear();
        #1;
        if (check_zero) begin
            chk("rst_bus", bus, 0);
            chk("rst_bus_x", bus_x, 0);
            chk("rst_bus_valid", bus_valid, 0);
            chk("rst_dout", dout, 0);
            chk("rst_dout_valid", dout_valid, 0);
            chk("rst_toggles", toggles, 0);
        end
        @(negedge ck);
        rst = 1'b0;
    endtask

    task automatic see(input string name, input logic [W-1:0] b, input logic x);
        @(posedge ck); #1;
        chk({name, "_bus"}, bus, b);
        chk({name, "_bus_x"}, bus_x, x);
    endtask

    // Monitor: compares every cycle's bus/counter state and every decoded word.
    initial begin
        cyc_t e;
        logic [W-1:0] w;
        forever begin
            @(posedge ck); #1;
            if (!rst) begin
                if (cyc_q.size() != 0) begin
                    e = cyc_q.pop_front();
                    chk("bus_valid", bus_valid, e.v);
                    chk("bus_valid_c", bus_valid_c, e.v);
                    if (e.v) begin
                        chk("bus", bus, e.b);
                        chk("bus_x", bus_x, e.x);
                        chk("bus_c", bus_c, e.b);
                        chk("bus_x_c", bus_x_c, e.x);
                    end
                    chk("toggles", toggles, e.tog);
                    chk("toggles_c", toggles_c, e.togc);
                end else if (bus_valid) begin
                    chk("unexpected_bus_valid", bus_valid, 0);
                end
                if (dout_valid) begin
                    if (dec_q.size() == 0) chk("unexpected_dout_valid", dout_valid, 0);
                    else begin
                        w = dec_q.pop_front();
                        chk("dout", dout, w);
                    end
                end
                if (dout_valid_c) begin
                    if (dec_c_q.size() == 0) chk("unexpected_dout_valid_c", dout_valid_c, 0);
                    else begin
                        w = dec_c_q.pop_front();
                        chk("dout_c", dout_c, w);
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0]   rm;
        logic [W-1:0] rd;
        model_clear();
        do_reset(1'b0);

        // T0 sequence from reset
        drive(1, 2'd2, 8'h10, 0); see("t0_a", 8'h10, 0);
        drive(1, 2'd2, 8'h11, 0); see("t0_b", 8'h10, 1);
        drive(1, 2'd2, 8'h12, 0); see("t0_c", 8'h10, 1);
        chk("t0_toggles", toggles, 2);

        // Gray
        drive(1, 2'd1, 8'h05, 0);
        drive(1, 2'd1, 8'h05, 0); see("gray_05", 8'h07, 0);
        drive(1, 2'd1, 8'hFF, 0); see("gray_ff", 8'h80, 0);

        // Bus-invert from a zero bus, then a tie
        do_reset(1'b0);
        drive(1, 2'd3, 8'hFE, 0); see("bi_fe", 8'h01, 1);
        drive(1, 2'd3, 8'hF0, 0); see("bi_f0", 8'h0F, 1);
        do_reset(1'b0);
        drive(1, 2'd3, 8'hF0, 0); see("bi_tie", 8'hF0, 0);

        // Mode switch clears T0 history
        do_reset(1'b0);
        drive(1, 2'd2, 8'h30, 0);
        drive(1, 2'd2, 8'h31, 0); see("sw_31", 8'h30, 1);
        drive(1, 2'd1, 8'h32, 0); see("sw_32", 8'h2B, 0);
        drive(1, 2'd2, 8'h33, 0); see("sw_33", 8'h33, 0);

        // Reset mid-stream in T0, then the next word goes out plain
        drive(1, 2'd2, 8'h1E, 0);
        drive(1, 2'd2, 8'h1F, 0);
        drive(1, 2'd2, 8'h20, 0);
        do_reset(1'b1);
        drive(1, 2'd2, 8'h21, 0); see("post_rst", 8'h21, 0);

        // Counter saturation on the 4-bit instance, then clear beating a flip
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) drive(1, 2'd0, (i % 2 == 1) ? 8'hFF : 8'h00, 0);
        @(posedge ck); #1;
        chk("sat_c", toggles_c, 15);
        chk("sat_16", toggles, 24);
        drive(1, 2'd0, 8'h00, 1);
        @(posedge ck); #1;
        chk("clr_16", toggles, 0);
        chk("clr_c", toggles_c, 0);

        // Random traffic
        rm = 2'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) rm = 2'($urandom_range(0, 3));
            rd = 8'($urandom);
            if (rm == 2'd2 && $urandom_range(0, 1) == 1) rd = W'(m_prev + W'(STRIDE));
            if (i == 300) do_reset(1'b1);
            drive($urandom_range(0, 9) < 8, rm, rd, $urandom_range(0, 19) == 0);
        end

        for (int i = 0; i < 4; i++) drive(0, rm, 8'h00, 0);
        @(posedge ck); #2;
        chk("drain", cyc_q.size() + dec_q.size() + dec_c_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
